// File: rtl/multicycle_control_unit_pkg.sv
// multicycle_control_unit_pkg: shared state encodings, RV32I opcodes, mux/ALU codes and control word
//   No ports; imported by the interface, the decode sub-module and the top.
package multicycle_control_unit_pkg;
   typedef enum logic [3:0] {
      S_IF   = 4'd0,
      S_ID   = 4'd1,
      S_EX   = 4'd2,
      S_MEM  = 4'd3,
      S_WB   = 4'd4,
      S_HALT = 4'd5
   } state_t;
   localparam logic [6:0] OP_LOAD      = 7'b0000011;
   localparam logic [6:0] OP_STORE     = 7'b0100011;
   localparam logic [6:0] OP_ARITH     = 7'b0110011;
   localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
   localparam logic [6:0] OP_BRANCH    = 7'b1100011;
   localparam logic [6:0] OP_JAL       = 7'b1101111;
   localparam logic [6:0] OP_JALR      = 7'b1100111;
   localparam logic [6:0] OP_ECALL     = 7'b1110011;
   localparam logic [1:0] SRC_B_RS2  = 2'd0;
   localparam logic [1:0] SRC_B_FOUR = 2'd1;
   localparam logic [1:0] SRC_B_IMM  = 2'd2;
   localparam logic [1:0] ALU_ADD    = 2'd0;
   localparam logic [1:0] ALU_BRANCH = 2'd1;
   localparam logic [1:0] ALU_FUNCT  = 2'd2;
   localparam logic [1:0] WB_ALUOUT  = 2'd0;
   localparam logic [1:0] WB_MDR     = 2'd1;
   localparam logic [1:0] WB_PC4     = 2'd2;
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       pc_source;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] wb_sel;
      logic       reg_write;
   } ctrl_t;
   // Opcodes that proceed past decode; anything else retires as a NOP from S_ID.
   function automatic logic is_exec_op(input logic [6:0] op);
      return op inside {OP_LOAD, OP_STORE, OP_ARITH, OP_ARITH_IMM, OP_BRANCH, OP_JAL, OP_JALR};
   endfunction
endpackage

// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: datapath <-> control unit bundle
//   opcode/bcond/is_halt_cond/mem_ready flow datapath -> control; ctrl (control word) flows back.
//   master: control unit side; slave: datapath side.
interface multicycle_control_unit_if;
   import multicycle_control_unit_pkg::*;
   logic [6:0] opcode;
   logic       bcond;
   logic       is_halt_cond;
   logic       mem_ready;
   ctrl_t      ctrl;
   modport master (input opcode, bcond, is_halt_cond, mem_ready, output ctrl);
   modport slave (output opcode, bcond, is_halt_cond, mem_ready, input ctrl);
endinterface

// File: rtl/multicycle_control_unit_output_decode.sv
// mcu_output_decode: combinational state + opcode -> control word
//   state, opcode in; fetch_done in (memory finished the fetch this cycle); ctrl out.
module mcu_output_decode
   import multicycle_control_unit_pkg::*;
(
   input  state_t     state,
   input  logic [6:0] opcode,
   input  logic       fetch_done,
   output ctrl_t      ctrl
);
   always_comb begin
      ctrl = '0;
      case (state)
         S_IF: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRC_B_FOUR;
            // PC and IR update only once the fetched word is actually there
            ctrl.ir_write  = fetch_done;
            ctrl.pc_write  = fetch_done;
         end
         S_ID: ctrl.alu_src_b = SRC_B_IMM;
         S_EX: begin
            ctrl.alu_src_a     = opcode != OP_JAL;
            ctrl.alu_src_b     = opcode inside {OP_ARITH_IMM, OP_LOAD, OP_STORE, OP_JALR} ? SRC_B_IMM : SRC_B_RS2;
            ctrl.alu_op        = opcode inside {OP_ARITH, OP_ARITH_IMM} ? ALU_FUNCT :
                                 opcode == OP_BRANCH ? ALU_BRANCH : ALU_ADD;
            ctrl.pc_write_cond = opcode == OP_BRANCH;
            ctrl.pc_source     = opcode inside {OP_BRANCH, OP_JAL};
            ctrl.pc_write      = opcode inside {OP_JAL, OP_JALR};
         end
         S_MEM: begin
            ctrl.i_or_d    = 1'b1;
            ctrl.mem_read  = opcode == OP_LOAD;
            ctrl.mem_write = opcode == OP_STORE;
         end
         S_WB: begin
            ctrl.reg_write = 1'b1;
            ctrl.wb_sel    = opcode == OP_LOAD ? WB_MDR :
                             opcode inside {OP_JAL, OP_JALR} ? WB_PC4 : WB_ALUOUT;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: RV32I multicycle control FSM with cycle / retired-instruction counters
//   clk, reset (async active-high) ; bus (master modport: opcode, bcond, is_halt_cond, mem_ready in, ctrl out)
//   halted, cycle_cnt, instr_cnt, dbg_state out.
//   Optional MEM_WAIT_EN: S_IF / S_MEM stall until mem_ready.
module multicycle_control_unit
   import multicycle_control_unit_pkg::*;
#(
   parameter int STATE_W = 4,
   parameter int CNT_W   = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   multicycle_control_unit_if.master   bus,
   output logic                        halted,
   output logic [CNT_W-1:0]            cycle_cnt,
   output logic [CNT_W-1:0]            instr_cnt,
   output logic [STATE_W-1:0]          dbg_state
);
   state_t state, next;
   logic   mem_done, retire, unused_ok;
   ctrl_t  ctrl;
`ifdef MEM_WAIT_EN
   assign mem_done = bus.mem_ready;
`else
   assign mem_done = 1'b1;
`endif
   // bcond is consumed by the datapath through pc_write_cond
   assign unused_ok = ^{bus.bcond, bus.mem_ready};
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IF;
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         state <= next;
         if (!halted) cycle_cnt <= cycle_cnt + CNT_W'(1);
         if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
      end
   end
   always_comb begin
      next = S_IF;
      case (state)
         S_IF:    next = mem_done ? S_ID : S_IF;
         S_ID:    next = bus.opcode == OP_ECALL ? (bus.is_halt_cond ? S_HALT : S_IF) :
                         is_exec_op(bus.opcode) ? S_EX : S_IF;
         S_EX:    next = bus.opcode inside {OP_LOAD, OP_STORE} ? S_MEM :
                         bus.opcode inside {OP_ARITH, OP_ARITH_IMM, OP_JAL, OP_JALR} ? S_WB : S_IF;
         S_MEM:   next = !mem_done ? S_MEM : bus.opcode == OP_LOAD ? S_WB : S_IF;
         S_WB:    next = S_IF;
         S_HALT:  next = S_HALT;
         default: next = S_IF;
      endcase
   end
   // Stray encodings falling back to S_IF are not instructions and do not retire.
   assign retire    = (next == S_IF && state inside {S_ID, S_EX, S_MEM, S_WB}) ||
                      (next == S_HALT && state == S_ID);
   assign halted    = state == S_HALT;
   assign dbg_state = STATE_W'(state);
   assign bus.ctrl  = ctrl;
   mcu_output_decode u_decode (
      .state      (state),
      .opcode     (bus.opcode),
      .fetch_done (mem_done),
      .ctrl       (ctrl)
   );
endmodule
